// File: rtl/matrix_pkg.sv
// Shared types, sizes and element slicing for the 4x4 x 16-bit matrix ALU.
package matrix_pkg;

  localparam int ELEM_W   = 16;
  localparam int DIM      = 4;
  localparam int NUM_ELEM = DIM * DIM;
  localparam int MAT_W    = NUM_ELEM * ELEM_W;

  typedef enum logic [2:0] {
    OP_ADD       = 3'd0,
    OP_SUB       = 3'd1,
    OP_MUL       = 3'd2,
    OP_TRANSPOSE = 3'd3,
    OP_SCALE     = 3'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Element [i][j] of a row-major packed matrix.
  function automatic logic [ELEM_W-1:0] elem(input logic [MAT_W-1:0] mat, input int i, input int j);
    return mat[(i * DIM + j) * ELEM_W +: ELEM_W];
  endfunction

endpackage

// File: rtl/matrix_alu_if.sv
// Request/response bundle between the Execution engine and matrix_alu.
interface matrix_alu_if;
  import matrix_pkg::*;

  // Start is a request that is accepted only on a rising edge where the ALU is
  // idle (Busy=0, Done=0); there is no back-pressure or queueing otherwise.
  // Done is a single-cycle pulse; Result and Error are meaningful while Done=1.
  logic             Start;
  logic [2:0]       Opcode;
  logic [MAT_W-1:0] SrcA;
  logic [MAT_W-1:0] SrcB;
  logic [MAT_W-1:0] Result;
  logic             Busy;
  logic             Done;
  logic             Error;
  state_e           DbgState;

  modport master (
    output Start, Opcode, SrcA, SrcB,
    input  Result, Busy, Done, Error, DbgState
  );

  modport slave (
    input  Start, Opcode, SrcA, SrcB,
    output Result, Busy, Done, Error, DbgState
  );

endinterface

// File: rtl/matrix_dot4.sv
// Combinational dot product of row `row` of A with column `col` of B, modulo 2^ELEM_W.
module matrix_dot4
  import matrix_pkg::*;
(
  input  logic [MAT_W-1:0]  matA,
  input  logic [MAT_W-1:0]  matB,
  input  logic [1:0]        row,
  input  logic [1:0]        col,
  output logic [ELEM_W-1:0] dot
);

  // Products are evaluated in ELEM_W-bit context, so each term is already truncated.
  always_comb begin
    dot = '0;
    for (int n = 0; n < DIM; n++) begin
      dot = dot + (elem(matA, int'(row), n) * elem(matB, n, int'(col)));
    end
  end

endmodule

// File: rtl/matrix_alu.sv
// Matrix ALU: single-cycle add/sub/transpose/scale, 16-cycle sequential multiply.
module matrix_alu
  import matrix_pkg::*;
(
  input  logic         Clk,
  input  logic         Reset,
  matrix_alu_if.slave  bus
);

  state_e           state;
  logic [3:0]       idx;
  logic [2:0]       opLat;
  logic [MAT_W-1:0] aLat;
  logic [MAT_W-1:0] bLat;
  logic [MAT_W-1:0] result;
  logic [MAT_W-1:0] addRes;
  logic [MAT_W-1:0] subRes;
  logic [MAT_W-1:0] trRes;
  logic [MAT_W-1:0] sclRes;
  logic [ELEM_W-1:0] dotRes;

  // Single-cycle results come straight from the bus so they land on the acceptance edge.
  for (genvar gi = 0; gi < DIM; gi++) begin : g_row
    for (genvar gj = 0; gj < DIM; gj++) begin : g_col
      localparam int LSB = (gi * DIM + gj) * ELEM_W;
      assign addRes[LSB +: ELEM_W] = elem(bus.SrcA, gi, gj) + elem(bus.SrcB, gi, gj);
      assign subRes[LSB +: ELEM_W] = elem(bus.SrcA, gi, gj) - elem(bus.SrcB, gi, gj);
      assign trRes[LSB +: ELEM_W]  = elem(bus.SrcA, gj, gi);
      assign sclRes[LSB +: ELEM_W] = elem(bus.SrcA, gi, gj) * elem(bus.SrcB, 0, 0);
    end
  end

  matrix_dot4 u_dot (
    .matA (aLat),
    .matB (bLat),
    .row  (idx[3:2]),
    .col  (idx[1:0]),
    .dot  (dotRes)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      idx    <= '0;
      opLat  <= '0;
      aLat   <= '0;
      bLat   <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            opLat <= bus.Opcode;
            aLat  <= bus.SrcA;
            bLat  <= bus.SrcB;
            idx   <= '0;
            state <= (bus.Opcode == OP_MUL) ? COMPUTE : DONE;
            case (bus.Opcode)
              OP_ADD:       result <= addRes;
              OP_SUB:       result <= subRes;
              OP_TRANSPOSE: result <= trRes;
              OP_SCALE:     result <= sclRes;
              default:      result <= result;
            endcase
          end
        end
        COMPUTE: begin
          result[{idx, 4'b0000} +: ELEM_W] <= dotRes;
          idx <= idx + 4'd1;
          if (idx == 4'd15) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Result   = result;
  assign bus.Busy     = (state != IDLE);
  assign bus.Done     = (state == DONE);
  assign bus.Error    = (state == DONE) && (opLat > OP_SCALE);
  assign bus.DbgState = state;

endmodule

// File: tb/tb_matrix_alu.sv
// Self-checking bench for matrix_alu: directed vector table, protocol/reset sequences, random vs model.
module tb_matrix_alu;
  import matrix_pkg::*;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  matrix_alu_if bus ();

  matrix_alu dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [255:0] a;
    logic [255:0] b;
    logic [255:0] exp;
    logic         exp_err;
    int           exp_lat;
  } vec_t;

  vec_t vecs[$];

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mat_fill(input int v);
    logic [255:0] m;
    for (int k = 0; k < 16; k++) m[k*16 +: 16] = 16'(v);
    return m;
  endfunction

  function automatic logic [255:0] mat_seq();
    logic [255:0] m;
    for (int k = 0; k < 16; k++) m[k*16 +: 16] = 16'(k + 1);
    return m;
  endfunction

  function automatic logic [255:0] mat_ident();
    logic [255:0] m;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) m[(i*4+j)*16 +: 16] = (i == j) ? 16'd1 : 16'd0;
    return m;
  endfunction

  function automatic logic [255:0] mat_rand();
    logic [255:0] m;
    for (int k = 0; k < 16; k++) m[k*16 +: 16] = 16'($urandom_range(0, 65535));
    return m;
  endfunction

  function automatic logic [15:0] get_el(input logic [255:0] m, input int i, input int j);
    return m[(i*4+j)*16 +: 16];
  endfunction

  // Reference: plain integer matrix arithmetic reduced modulo 2^16.
  function automatic logic [255:0] model(input logic [2:0] op, input logic [255:0] a,
                                         input logic [255:0] b, input logic [255:0] prev);
    longint ma[4][4];
    longint mb[4][4];
    longint r[4][4];
    logic [255:0] out;
    if (op > 3'd4) return prev;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = longint'(get_el(a, i, j));
        mb[i][j] = longint'(get_el(b, i, j));
      end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        case (op)
          3'd0: r[i][j] = (ma[i][j] + mb[i][j]) % 65536;
          3'd1: r[i][j] = (ma[i][j] - mb[i][j] + 65536) % 65536;
          3'd2: begin
            r[i][j] = 0;
            for (int n = 0; n < 4; n++) r[i][j] += ma[i][n] * mb[n][j];
            r[i][j] = r[i][j] % 65536;
          end
          3'd3: r[i][j] = ma[j][i];
          default: r[i][j] = (ma[i][j] * mb[0][0]) % 65536;
        endcase
        out[(i*4+j)*16 +: 16] = 16'(r[i][j]);
      end
    return out;
  endfunction

  // Issues one op and waits (bounded) for Done; lat counts edges from the Start cycle.
  task automatic run_op(input logic [2:0] op, input logic [255:0] a, input logic [255:0] b,
                        output logic [255:0] res, output logic err, output int lat,
                        output logic got_done, output logic pulse_ok);
    @(negedge clk);
    bus.Start  = 1'b1;
    bus.Opcode = op;
    bus.SrcA   = a;
    bus.SrcB   = b;
    @(negedge clk);
    bus.Start  = 1'b0;
    bus.Opcode = 3'($urandom_range(0, 7));
    bus.SrcA   = mat_rand();
    bus.SrcB   = mat_rand();
    lat = 1;
    while (!bus.Done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    got_done = bus.Done;
    res      = bus.Result;
    err      = bus.Error;
    @(negedge clk);
    pulse_ok = !bus.Done && !bus.Busy;
  endtask

  task automatic check_op(input string name, input logic [2:0] op, input logic [255:0] a,
                          input logic [255:0] b, input logic [255:0] exp, input logic exp_err,
                          input int exp_lat);
    logic [255:0] res;
    logic err, got_done, pulse_ok;
    int lat;
    run_op(op, a, b, res, err, lat, got_done, pulse_ok);
    check({name, "_done"}, 256'(got_done), 256'(1));
    check({name, "_lat"}, 256'(lat), 256'(exp_lat));
    check({name, "_res"}, res, exp);
    check({name, "_err"}, 256'(err), 256'(exp_err));
    check({name, "_pulse"}, 256'(pulse_ok), 256'(1));
  endtask

  // ---------------- test ----------------
  logic [255:0] prev_exp;
  logic [255:0] exp_tr;
  logic [255:0] r;
  logic e, gd, po;
  int lat, dones, done_at;
  logic busy_ok;

  initial begin
    reset      = 1'b1;
    bus.Start  = 1'b0;
    bus.Opcode = 3'd0;
    bus.SrcA   = '0;
    bus.SrcB   = '0;

    // Table of directed vectors
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) exp_tr[(i*4+j)*16 +: 16] = 16'(4*j + i + 1);
    vecs.push_back('{"add_3_2", 3'd0, mat_fill(3), mat_fill(2), mat_fill(5), 1'b0, 1});
    begin
      logic [255:0] sa, se;
      sa = mat_fill(5); sa[15:0] = 16'd0;
      se = mat_fill(4); se[15:0] = 16'hFFFF;
      vecs.push_back('{"sub_wrap", 3'd1, sa, mat_fill(1), se, 1'b0, 1});
    end
    vecs.push_back('{"add_wrap", 3'd0, mat_fill(16'hFFFF), mat_fill(1), mat_fill(0), 1'b0, 1});
    vecs.push_back('{"mul_ident", 3'd2, mat_ident(), mat_seq(), mat_seq(), 1'b0, 17});
    vecs.push_back('{"mul_2x3", 3'd2, mat_fill(2), mat_fill(3), mat_fill(24), 1'b0, 17});
    vecs.push_back('{"transpose", 3'd3, mat_seq(), mat_rand(), exp_tr, 1'b0, 1});
    vecs.push_back('{"scale_7x3", 3'd4, mat_fill(7), mat_fill(3), mat_fill(21), 1'b0, 1});
    vecs.push_back('{"illegal_6", 3'd6, mat_rand(), mat_rand(), mat_fill(21), 1'b1, 1});

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_result", bus.Result, 256'(0));
    check("rst_busy", 256'(bus.Busy), 256'(0));
    check("rst_done", 256'(bus.Done), 256'(0));
    check("rst_error", 256'(bus.Error), 256'(0));
    check("rst_state", 256'(bus.DbgState), 256'(IDLE));

    foreach (vecs[k])
      check_op(vecs[k].name, vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].exp,
               vecs[k].exp_err, vecs[k].exp_lat);

    // Spot elements of a transpose
    run_op(3'd3, mat_seq(), mat_fill(0), r, e, lat, gd, po);
    check("tr_r01", 256'(get_el(r, 0, 1)), 256'(5));
    check("tr_r30", 256'(get_el(r, 3, 0)), 256'(4));

    // Start pulses during a MUL are ignored
    @(negedge clk);
    bus.Start = 1'b1; bus.Opcode = 3'd2; bus.SrcA = mat_fill(2); bus.SrcB = mat_fill(3);
    dones = 0; done_at = 0; busy_ok = 1'b1; r = '0;
    for (int n = 1; n <= 22; n++) begin
      @(negedge clk);
      bus.Start  = (n == 3 || n == 10);
      bus.Opcode = 3'd0;
      if (bus.Done) begin
        dones++;
        done_at = n;
        r = bus.Result;
      end
      if (n <= 17 && !bus.Busy) busy_ok = 1'b0;
    end
    bus.Start = 1'b0;
    check("proto_done_count", 256'(dones), 256'(1));
    check("proto_done_at", 256'(done_at), 256'(17));
    check("proto_busy", 256'(busy_ok), 256'(1));
    check("proto_result", r, mat_fill(24));

    // Reset in the middle of a MUL
    @(negedge clk);
    bus.Start = 1'b1; bus.Opcode = 3'd2; bus.SrcA = mat_ident(); bus.SrcB = mat_seq();
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      bus.Start = 1'b0;
    end
    check("mid_state", 256'(bus.DbgState), 256'(COMPUTE));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_state", 256'(bus.DbgState), 256'(IDLE));
    check("rstmid_result", bus.Result, 256'(0));
    check("rstmid_busy", 256'(bus.Busy), 256'(0));
    dones = 0;
    for (int n = 0; n < 20; n++) begin
      if (bus.Done) dones++;
      @(negedge clk);
    end
    check("rstmid_no_done", 256'(dones), 256'(0));
    check_op("add_after_rst", 3'd0, mat_fill(3), mat_fill(2), mat_fill(5), 1'b0, 1);
    prev_exp = mat_fill(5);

    // Random ops against the model
    for (int k = 0; k < 30; k++) begin
      logic [2:0] op;
      logic [255:0] a, b, exp;
      op  = 3'($urandom_range(0, 7));
      a   = mat_rand();
      b   = mat_rand();
      exp = model(op, a, b, prev_exp);
      check_op($sformatf("rand%0d_op%0d", k, op), op, a, b, exp, (op > 3'd4),
               (op == 3'd2) ? 17 : 1);
      prev_exp = exp;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
